// File: rtl/bip_debug_pkg.sv
// Shared types and constants for the BIP UART debug unit.
package bip_debug_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_SEND = 2'd3
  } state_t;

  localparam logic [7:0] CMD_START_DEF = 8'h08;
  localparam logic [7:0] CMD_STEP_DEF  = 8'h09;

  // Report frame length: full count bytes followed by the zero-padded accumulator.
  function automatic int frame_bytes(input int cnt_w, input int data_w);
    return cnt_w / 8 + (data_w + 7) / 8;
  endfunction

endpackage

// File: rtl/bip_debug_if.sv
// UART FIFO side of the debug unit: RX pop and TX push handshakes.
interface bip_debug_if;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       tx_full;
  logic [7:0] w_data;
  logic       wr_uart;

  modport master (input rx_empty, r_data, tx_full, output rd_uart, w_data, wr_uart);
  modport slave  (output rx_empty, r_data, tx_full, input rd_uart, w_data, wr_uart);
endinterface

// File: rtl/bip_debug_frame_ser.sv
// Snapshot register and byte serializer for the count/accumulator report frame.
module bip_debug_frame_ser
  import bip_debug_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [CNT_WIDTH-1:0]  cnt,
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic                  send,
  input  logic                  tx_full,
  output logic                  wr_uart,
  output logic [7:0]            w_data,
  output logic                  done
);

  localparam int NBYTES = frame_bytes(CNT_WIDTH, DATA_WIDTH);
  localparam int ACC_W  = NBYTES * 8 - CNT_WIDTH;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  logic [NBYTES-1:0][7:0] frame;
  logic [IDX_W-1:0]       idx;

  assign wr_uart = send & ~tx_full;
  assign w_data  = frame[idx];
  assign done    = wr_uart && (idx == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame <= '0;
      idx   <= '0;
    end else begin
      if (load) frame <= {ACC_W'(acc), cnt};
      if (done)         idx <= '0;
      else if (wr_uart) idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/bip_debug_unit.sv
// UART debug controller for the BIP CPU: runs or single-steps the CPU and reports the
// saturating cycle count and accumulator. Step mode is built only with BIP_DEBUG_STEP_EN.
module bip_debug_unit
  import bip_debug_pkg::*;
#(
  parameter int         DATA_WIDTH = 16,
  parameter int         CNT_WIDTH  = 32,
  parameter logic [7:0] CMD_START  = CMD_START_DEF
`ifdef BIP_DEBUG_STEP_EN
  , parameter logic [7:0] CMD_STEP = CMD_STEP_DEF
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  bip_debug_if.master           uart,
  input  logic                  pc_en,
  input  logic [DATA_WIDTH-1:0] acc,
  output logic                  cpu_reset,
  output logic                  cpu_en,
  output logic                  busy
);

  state_t               state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_sat, snap_cnt;
  logic                 first;
  logic                 rx_pop, is_start, load, send, ser_done, cnt_clr, cnt_inc;
`ifdef BIP_DEBUG_STEP_EN
  logic                 is_step, step_go, step_snap, halt_s, final_f;
  assign is_step = (uart.r_data == CMD_STEP);
`endif

  assign is_start    = (uart.r_data == CMD_START);
  assign uart.rd_uart = rx_pop;
  assign cnt_sat     = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
  // RUN snapshots include the halting cycle; a step has already counted its cycle.
  assign snap_cnt    = (state == S_RUN) ? cnt_sat : cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (rx_pop && is_start) state_n = S_RUN;
`ifdef BIP_DEBUG_STEP_EN
              else if (rx_pop && is_step) state_n = S_STEP;
      S_STEP: if (step_snap) state_n = S_SEND;
              else if (rx_pop && is_start) state_n = S_RUN;
`endif
      S_RUN:  if (load) state_n = S_SEND;
`ifdef BIP_DEBUG_STEP_EN
      S_SEND: if (ser_done) state_n = final_f ? S_IDLE : S_STEP;
`else
      S_SEND: if (ser_done) state_n = S_IDLE;
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    rx_pop    = 1'b0;
    cpu_en    = 1'b0;
    cpu_reset = 1'b0;
    busy      = 1'b1;
    load      = 1'b0;
    send      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        cpu_reset = 1'b1;
        busy      = 1'b0;
        rx_pop    = ~uart.rx_empty & ~reset;
`ifdef BIP_DEBUG_STEP_EN
        cnt_clr   = rx_pop & (is_start | is_step);
`else
        cnt_clr   = rx_pop & is_start;
`endif
      end
      S_RUN: begin
        cpu_en  = 1'b1;
        cnt_inc = 1'b1;
        load    = ~first & ~pc_en;
      end
`ifdef BIP_DEBUG_STEP_EN
      S_STEP: begin
        cpu_en  = step_go;
        cnt_inc = step_go;
        load    = step_snap;
        rx_pop  = ~uart.rx_empty & ~reset & ~step_go & ~step_snap;
      end
`endif
      S_SEND: send = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      first <= 1'b0;
`ifdef BIP_DEBUG_STEP_EN
      step_go   <= 1'b0;
      step_snap <= 1'b0;
      halt_s    <= 1'b0;
      final_f   <= 1'b0;
`endif
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt_sat;
      // pc_en is not meaningful in the first cycle after the CPU is released.
      first <= (state != S_RUN) && (state_n == S_RUN);
`ifdef BIP_DEBUG_STEP_EN
      step_go   <= rx_pop & is_step;
      step_snap <= step_go;
      if (step_go) halt_s <= ~pc_en;
      if (load)    final_f <= (state == S_RUN) | halt_s;
`endif
    end
  end

  bip_debug_frame_ser #(
    .CNT_WIDTH (CNT_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .cnt    (snap_cnt),
    .acc    (acc),
    .send   (send),
    .tx_full(uart.tx_full),
    .wr_uart(uart.wr_uart),
    .w_data (uart.w_data),
    .done   (ser_done)
  );

endmodule

// File: tb/tb_bip_debug_unit.sv
// Directed bench for bip_debug_unit: run/halt frames, backpressure, saturation, reset, step mode.
module tb_bip_debug_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bip_debug_if u ();
  bip_debug_if u8 ();
  logic        pc_en, pc_en8;
  logic [15:0] acc, acc8;
  logic        cpu_reset, cpu_en, busy, cpu_reset8, cpu_en8, busy8;

  bip_debug_unit dut (
    .clk(clk), .reset(reset), .uart(u), .pc_en(pc_en), .acc(acc),
    .cpu_reset(cpu_reset), .cpu_en(cpu_en), .busy(busy)
  );

  bip_debug_unit #(.CNT_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .uart(u8), .pc_en(pc_en8), .acc(acc8),
    .cpu_reset(cpu_reset8), .cpu_en(cpu_en8), .busy(busy8)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int en_cnt = 0;
  logic [7:0] txq[$];
  logic [7:0] tx8[$];
  int         txc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u.wr_uart) begin
      txq.push_back(u.w_data);
      txc.push_back(cyc);
    end
    if (u.rd_uart) rd_cnt++;
    if (cpu_en) en_cnt++;
    if (u8.wr_uart) tx8.push_back(u8.w_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    u.rx_empty = 1'b0;
    u.r_data   = b;
    tick();
    u.rx_empty = 1'b1;
  endtask

  // pc_en stays high for n-1 RUN cycles and drops on the n-th.
  task automatic run_cycles(input int n);
    for (int i = 1; i <= n; i++) begin
      pc_en = (i != n);
      tick();
    end
    pc_en = 1'b1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60 && busy; k++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    u.rx_empty = 1'b1; u.r_data = 8'h00; u.tx_full = 1'b0; pc_en = 1'b1; acc = 16'h0;
    u8.rx_empty = 1'b1; u8.r_data = 8'h00; u8.tx_full = 1'b0; pc_en8 = 1'b1; acc8 = 16'h0;
    repeat (2) tick();
    checks++; if (u.rd_uart !== 1'b0) begin errors++; $display("FAIL reset rd_uart: got %b want 0", u.rd_uart); end
    checks++; if (u.wr_uart !== 1'b0) begin errors++; $display("FAIL reset wr_uart: got %b want 0", u.wr_uart); end
    checks++; if (u.w_data !== 8'h00) begin errors++; $display("FAIL reset w_data: got %h want 00", u.w_data); end
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset cpu_reset: got %b want 1", cpu_reset); end
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset cpu_en: got %b want 0", cpu_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_run_halt();
    int b = txq.size();
    int r0 = rd_cnt;
    logic [47:0] exp = 48'hBEEF_0000_0005;
    acc = 16'hBEEF;
    send_byte(8'h08);
    checks++; if (cpu_reset !== 1'b0 || cpu_en !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL run_start rst/en/busy: got %b%b%b want 011", cpu_reset, cpu_en, busy); end
    run_cycles(5);
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL run_halt cpu_en: got %b want 0", cpu_en); end
    wait_idle();
    checks++; if (busy !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++; $display("FAIL run_end busy/cpu_reset: got %b%b want 01", busy, cpu_reset); end
    checks++; if (rd_cnt - r0 != 1) begin errors++; $display("FAIL run_rd_pulses: got %0d want 1", rd_cnt - r0); end
    checks++; if (txq.size() - b != 6) begin
      errors++; $display("FAIL run_push_count: got %0d want 6", txq.size() - b);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (txq[b+i] !== exp[i*8+:8]) begin
          errors++; $display("FAIL run_byte%0d: got %h want %h", i, txq[b+i], exp[i*8+:8]); end
      end
      checks++; if (txc[b+5] - txc[b] != 5) begin
        errors++; $display("FAIL run_consecutive: span %0d want 5", txc[b+5] - txc[b]); end
    end
  endtask

  task automatic test_backpressure();
    int b = txq.size();
    logic [47:0] exp = 48'hBEEF_0000_0005;
    acc = 16'hBEEF;
    send_byte(8'h08);
    run_cycles(5);
    tick(); tick();
    u.tx_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (u.wr_uart !== 1'b0) begin errors++; $display("FAIL bp_stall%0d wr_uart: got %b want 0", k, u.wr_uart); end
      tick();
    end
    u.tx_full = 1'b0;
    wait_idle();
    checks++; if (txq.size() - b != 6) begin
      errors++; $display("FAIL bp_push_count: got %0d want 6", txq.size() - b);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (txq[b+i] !== exp[i*8+:8]) begin
          errors++; $display("FAIL bp_byte%0d: got %h want %h", i, txq[b+i], exp[i*8+:8]); end
      end
      checks++; if (txc[b+5] - txc[b] != 8) begin
        errors++; $display("FAIL bp_span: got %0d want 8", txc[b+5] - txc[b]); end
    end
  endtask

  task automatic test_unknown_cmd();
    int b = txq.size();
    int r0 = rd_cnt;
    send_byte(8'h41);
    checks++; if (busy !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++; $display("FAIL unknown busy/cpu_reset: got %b%b want 01", busy, cpu_reset); end
    repeat (4) tick();
    checks++; if (rd_cnt - r0 != 1) begin errors++; $display("FAIL unknown_rd_pulses: got %0d want 1", rd_cnt - r0); end
    checks++; if (txq.size() != b) begin errors++; $display("FAIL unknown_tx: got %0d pushes want 0", txq.size() - b); end
  endtask

  task automatic test_saturate();
    logic [23:0] exp = 24'h1234_FF;
    acc8 = 16'h1234;
    u8.rx_empty = 1'b0; u8.r_data = 8'h08;
    tick();
    u8.rx_empty = 1'b1;
    for (int i = 1; i <= 301; i++) begin
      pc_en8 = (i != 301);
      tick();
    end
    pc_en8 = 1'b1;
    for (int k = 0; k < 40 && busy8; k++) tick();
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL sat_timeout busy: got %b want 0", busy8); end
    checks++; if (tx8.size() != 3) begin
      errors++; $display("FAIL sat_push_count: got %0d want 3", tx8.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (tx8[i] !== exp[i*8+:8]) begin
          errors++; $display("FAIL sat_byte%0d: got %h want %h", i, tx8[i], exp[i*8+:8]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int b = txq.size();
    logic [47:0] exp = 48'hA55A_0000_0002;
    acc = 16'h1234;
    send_byte(8'h08);
    run_cycles(3);
    tick(); tick();
    reset = 1'b1;
    #1;
    checks++; if (txq.size() - b != 2) begin errors++; $display("FAIL rstmid_pushes_before: got %0d want 2", txq.size() - b); end
    checks++; if (u.wr_uart !== 1'b0 || u.w_data !== 8'h00) begin
      errors++; $display("FAIL rstmid wr_uart/w_data: got %b/%h want 0/00", u.wr_uart, u.w_data); end
    checks++; if (cpu_reset !== 1'b1 || cpu_en !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid rst/en/busy: got %b%b%b want 100", cpu_reset, cpu_en, busy); end
    #2;
    reset = 1'b0;
    tick();
    b = txq.size();
    acc = 16'hA55A;
    send_byte(8'h08);
    run_cycles(2);
    wait_idle();
    checks++; if (txq.size() - b != 6) begin
      errors++; $display("FAIL rstmid_push_count: got %0d want 6", txq.size() - b);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (txq[b+i] !== exp[i*8+:8]) begin
          errors++; $display("FAIL rstmid_byte%0d: got %h want %h", i, txq[b+i], exp[i*8+:8]); end
      end
    end
  endtask

  task automatic test_step();
`ifdef BIP_DEBUG_STEP_EN
    int b = txq.size();
    int e0 = en_cnt;
    logic [47:0] exp1 = 48'h0011_0000_0001;
    logic [47:0] exp2 = 48'h0022_0000_0002;
    logic [47:0] exp3 = 48'h0033_0000_0005;
    acc = 16'h0011;
    send_byte(8'h09);
    for (int k = 0; k < 40 && txq.size() - b < 6; k++) tick();
    checks++; if (busy !== 1'b1 || cpu_reset !== 1'b0) begin
      errors++; $display("FAIL step1 busy/cpu_reset: got %b%b want 10", busy, cpu_reset); end
    checks++; if (en_cnt - e0 != 1) begin errors++; $display("FAIL step1_en_cycles: got %0d want 1", en_cnt - e0); end
    acc = 16'h0022;
    send_byte(8'h09);
    for (int k = 0; k < 40 && txq.size() - b < 12; k++) tick();
    checks++; if (en_cnt - e0 != 2) begin errors++; $display("FAIL step2_en_cycles: got %0d want 2", en_cnt - e0); end
    acc = 16'h0033;
    send_byte(8'h08);
    run_cycles(3);
    wait_idle();
    checks++; if (busy !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++; $display("FAIL step_final busy/cpu_reset: got %b%b want 01", busy, cpu_reset); end
    checks++; if (txq.size() - b != 18) begin
      errors++; $display("FAIL step_push_count: got %0d want 18", txq.size() - b);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (txq[b+i] !== exp1[i*8+:8]) begin
          errors++; $display("FAIL step1_byte%0d: got %h want %h", i, txq[b+i], exp1[i*8+:8]); end
        checks++; if (txq[b+6+i] !== exp2[i*8+:8]) begin
          errors++; $display("FAIL step2_byte%0d: got %h want %h", i, txq[b+6+i], exp2[i*8+:8]); end
        checks++; if (txq[b+12+i] !== exp3[i*8+:8]) begin
          errors++; $display("FAIL step_run_byte%0d: got %h want %h", i, txq[b+12+i], exp3[i*8+:8]); end
      end
    end
`else
    int b = txq.size();
    send_byte(8'h09);
    checks++; if (busy !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++; $display("FAIL nostep busy/cpu_reset: got %b%b want 01", busy, cpu_reset); end
    repeat (4) tick();
    checks++; if (txq.size() != b) begin errors++; $display("FAIL nostep_tx: got %0d pushes want 0", txq.size() - b); end
`endif
  endtask

  initial begin
    test_reset();
    test_run_halt();
    test_backpressure();
    test_unknown_cmd();
    test_saturate();
    test_reset_mid();
    test_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/bip_debug_unit.md
# bip_debug_unit

Parametrised UART debug controller for the BIP processor: decodes command bytes from the UART receive FIFO, holds and releases the CPU, and measures execution length in clock cycles. On program halt, or after each single step, it snapshots the cycle count and the accumulator and sends them as a multi-byte little-endian frame through the UART transmit FIFO. It sits in the bip top level between the uart instance and the cpu instance, replacing the fixed two-byte report logic, with a wider, saturating counter and a run/step mode.

## Interface
- DATA_WIDTH, 16: accumulator width; transmitted as ceil(DATA_WIDTH/8) bytes, zero-padded.
- CNT_WIDTH, 32: cycle counter width, multiple of 8; transmitted as CNT_WIDTH/8 bytes.
- CMD_START, 8'h08: run-to-halt command.
- CMD_STEP, 8'h09: single-step command (used only with step mode compiled in).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- rx_empty  in  1  UART RX FIFO empty.
- r_data  in  8  RX FIFO head byte.
- rd_uart  out  1  RX pop strobe, one cycle per consumed byte.
- tx_full  in  1  UART TX FIFO full.
- w_data  out  8  TX byte, valid while wr_uart=1.
- wr_uart  out  1  TX push strobe.
- pc_en  in  1  CPU PC write enable; 0 while running = program halted.
- acc  in  DATA_WIDTH  CPU accumulator.
- cpu_reset  out  1  CPU reset, 1 = CPU held at address 0.
- cpu_en  out  1  CPU clock enable.
- busy  out  1  1 in any state other than IDLE.

## Operation
- States: IDLE, RUN, STEP (macro only), SEND.
- IDLE: cpu_reset=1, cpu_en=0. When rx_empty=0, pulse rd_uart for one cycle and consume the byte, whatever its value. On CMD_START: clear the counter, cpu_reset<=0, go to RUN. On CMD_STEP: clear the counter, cpu_reset<=0, go to STEP. Other bytes are discarded.
- RUN: cpu_en=1. The counter increments every RUN cycle and saturates at 2^CNT_WIDTH-1 with no wrap. pc_en is ignored in the first RUN cycle. From the second cycle on, pc_en=0 triggers the following on that same edge:
  - snapshot count (including the current cycle) and acc;
  - cpu_en<=0;
  - mark the frame final;
  - go to SEND.
- RUN does not read RX; bytes stay queued.
- SEND: the frame is NBYTES = CNT_WIDTH/8 + ceil(DATA_WIDTH/8) bytes. The count goes first, then acc, each LSB first. Byte index idx starts at 0.
  - Each cycle with tx_full=0: wr_uart=1, w_data=frame[idx], idx++.
  - With tx_full=1: wr_uart=0 and idx holds.
  - After byte NBYTES-1: go to IDLE (cpu_reset=1) if the frame is final, else back to STEP.
- The snapshot is stable for the whole of SEND, whatever the CPU does.
- Reset mid-operation: state returns to IDLE immediately. The frame in progress is abandoned, the counter, snapshot and idx are cleared, and cpu_reset=1.

## Timing
- Reset values: rd_uart=0, wr_uart=0, w_data=8'h00, cpu_reset=1, cpu_en=0, busy=0.
- rd_uart and wr_uart are combinational from registered state and the FIFO flags. w_data is combinational from the snapshot and idx.
- Command byte visible at cycle t: rd_uart=1 at t; cpu_reset=0 and state RUN from t+1.
- Halt detected at cycle h: cpu_en=0 at h+1; the first wr_uart is at h+1 if tx_full=0.
- With no backpressure, SEND lasts exactly NBYTES cycles. busy deasserts the cycle after the last push.
- Saturation: at the all-ones count, further RUN cycles leave the count unchanged.

## Configuration
- BIP_DEBUG_STEP_EN defined: the STEP state and CMD_STEP decoding exist. STEP behaviour:
  - Holds cpu_en=0 and pops RX bytes as IDLE does.
  - CMD_STEP: cpu_en=1 for exactly one cycle and the counter increments once. The next cycle snapshots count and acc and goes to SEND, non-final, returning to STEP afterwards. If pc_en=0 was sampled during the enabled cycle, the frame is final instead.
  - CMD_START: go to RUN without clearing the counter.
  - Other bytes are discarded.
- BIP_DEBUG_STEP_EN undefined: CMD_STEP is treated as an unknown byte in IDLE, and no STEP logic is synthesised.

## Structure
- Package bip_debug_pkg holds:
  - the state enumeration;
  - the default command codes;
  - a constant function returning NBYTES from CNT_WIDTH and DATA_WIDTH.
- Sub-module bip_debug_frame_ser holds:
  - the snapshot register;
  - idx;
  - byte selection;
  - the wr_uart/tx_full handshake;
  - a done pulse.
- The controller FSM stays in bip_debug_unit.

## Test plan
- Reset, then CMD_START; pc_en=1 for 4 RUN cycles, then 0 on the 5th, acc=16'hBEEF -> rd_uart pulses once; bytes 05 00 00 00 EF BE, pushed on 6 consecutive cycles; then cpu_reset=1 and busy=0.
- Same as the first scenario but tx_full=1 for 3 cycles after byte 2 -> no push while full; byte order intact; exactly 6 pushes.
- Byte 8'h41 in IDLE -> rd_uart pulse, stays in IDLE, cpu_reset stays 1, no TX.
- CNT_WIDTH=8, program never halts for 300 cycles, then halts -> count byte 8'hFF.
- reset asserted after 2 pushed bytes -> outputs return to reset values at once; the next CMD_START frame starts with the count LSB.
- BIP_DEBUG_STEP_EN: CMD_STEP, CMD_STEP (pc_en=1) -> two frames with counts 1 and 2, cpu_en high exactly one cycle per step; then CMD_START, halt after 3 RUN cycles -> count 5, final frame, IDLE.
